move_replayer: RTL and testbench

//  Downstream of the register file. When the solver raises comp, it captures the

---
 rtl/move_replayer_if.sv | 35 +++
 rtl/move_replayer.sv | 235 +++++++++++++++++++++++
 tb/tb_move_replayer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_replayer_if.sv
// -----------------------------------------------------------------------------
// move_replayer_if
//  Output stream from the move replayer to the display/UART stage.
//  One board per valid/ready handshake.
//  Signals:
//   out_state  [17:0]  board after step_idx moves (3 bits per cell, 6 cells)
//   step_idx   [4:0]   number of moves applied to out_state
//   out_valid          out_state/step_idx/out_last are valid
//   out_ready          sink accepts when out_valid & out_ready
//   out_last           high with the final board of the replay
//  Modports: master (replayer side), slave (sink side).
// -----------------------------------------------------------------------------
interface move_replayer_if;
   logic [17:0] out_state;
   logic [4:0]  step_idx;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (
      output out_state,
      output step_idx,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_state,
      input  step_idx,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/move_replayer.sv
// -----------------------------------------------------------------------------
// move_replayer
//  Replays a solver's move list on the 2x3 sliding-tile board. On a rising edge
//  of i_comp the move order, move count and start board are captured, then every
//  intermediate board (start board included) is emitted on out_if, one per
//  handshake. Cell i = 3*row + col sits at bits [3i+2:3i]; tile 0 is the blank.
//  Move codes move the blank: 00 up, 01 right, 10 down, 11 left.
//
//  Optional feature macro: MOVE_REPLAY_GOAL_CHECK_EN
//   defined   : on the last accept the final board is compared with GOAL;
//               mismatch ends in the error state with no done pulse.
//   undefined : no comparison, the last accept always completes normally.
//
//  Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   i_start_state  start board, bits [17:0] used
//   i_comp         solver-complete flag, replay starts on its 0->1 edge
//   i_cnt          move count, n = min(i_cnt[4:0], MAX_MOVES)
//   i_ord          packed move list, move k at [2k+1:2k]
//   out_if         board stream (master modport)
//   o_busy         replay in progress (not idle, not in error)
//   o_done         one-cycle pulse after the final board is accepted
//   o_err          sticky illegal-move / no-blank / goal-mismatch flag
// -----------------------------------------------------------------------------
module move_replayer #(
   parameter int          MAX_MOVES = 20,
   parameter logic [17:0] GOAL      = 18'o543210
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [25:0]     i_start_state,
   input  logic            i_comp,
   input  logic [25:0]     i_cnt,
   input  logic [43:0]     i_ord,
   move_replayer_if.master out_if,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err
);
   localparam int         ORD_W = 2 * MAX_MOVES;
   localparam logic [4:0] MAX_N = 5'(MAX_MOVES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_EMIT, S_APPLY, S_DONE, S_ERR
   } state_t;

   state_t           r_state;
   logic             r_comp_q;
   logic             r_comp_armed;
   logic [ORD_W-1:0] r_ord;
   logic [4:0]       r_n;
   logic [17:0]      r_board;
   logic [2:0]       r_blank;
   logic [4:0]       r_step;
   logic             r_valid;
   logic             r_last;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_comp_rise;
   logic             w_accept;
   logic [4:0]       w_n;
   logic [5:0]       w_is_blank;
   logic             w_blank_found;
   logic [2:0]       w_blank_pos;
   logic [ORD_W-1:0] w_ord_sh;
   logic [1:0]       w_move;
   logic             w_row1;
   logic [2:0]       w_col;
   logic             w_legal;
   logic [2:0]       w_target;
   logic [2:0]       w_tgt_tile;
   logic [17:0]      w_next_board;
   logic             w_goal_ok;
   logic [3:0]       w_unused_bits;

   // The edge register only becomes trustworthy one cycle after reset, so a comp
   // that is already high when reset releases is not mistaken for a new edge.
   assign w_comp_rise = i_comp & ~r_comp_q & r_comp_armed;
   assign w_accept    = r_valid & out_if.out_ready;
   assign w_n         = (i_cnt[4:0] > MAX_N) ? MAX_N : i_cnt[4:0];

   // Blank search on the incoming start board; lowest blank cell wins.
   for (genvar gi = 0; gi < 6; gi++) begin : g_blank
      assign w_is_blank[gi] = (i_start_state[3*gi +: 3] == 3'd0);
   end
   assign w_blank_found = |w_is_blank;

   always_comb begin
      w_blank_pos = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (w_is_blank[i]) w_blank_pos = 3'(i);
      end
   end

   // Current move and its legality against the blank's row/column.
   assign w_ord_sh = r_ord >> {r_step, 1'b0};
   assign w_move   = w_ord_sh[1:0];
   assign w_row1   = (r_blank >= 3'd3);
   assign w_col    = w_row1 ? (r_blank - 3'd3) : r_blank;

   always_comb begin
      w_legal  = 1'b0;
      w_target = r_blank;
      case (w_move)
         2'b00:   begin w_legal = w_row1;          w_target = r_blank - 3'd3; end
         2'b01:   begin w_legal = (w_col != 3'd2); w_target = r_blank + 3'd1; end
         2'b10:   begin w_legal = ~w_row1;         w_target = r_blank + 3'd3; end
         default: begin w_legal = (w_col != 3'd0); w_target = r_blank - 3'd1; end
      endcase
   end

   always_comb begin
      w_tgt_tile = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (w_target == 3'(i)) w_tgt_tile = r_board[3*i +: 3];
      end
   end

   // Swap: the target cell becomes blank, the old blank takes the target's tile.
   for (genvar gi = 0; gi < 6; gi++) begin : g_swap
      assign w_next_board[3*gi +: 3] = (w_target == 3'(gi)) ? 3'd0 :
                                       (r_blank  == 3'(gi)) ? w_tgt_tile :
                                                              r_board[3*gi +: 3];
   end

`ifdef MOVE_REPLAY_GOAL_CHECK_EN
   assign w_goal_ok = (r_board == GOAL);
`else
   assign w_goal_ok = 1'b1;
`endif

   assign w_unused_bits = {^i_start_state[25:18], ^i_cnt[25:5], ^i_ord[43:ORD_W], ^GOAL};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_comp_q     <= 1'b0;
         r_comp_armed <= 1'b0;
         r_ord        <= '0;
         r_n          <= '0;
         r_board      <= '0;
         r_blank      <= '0;
         r_step       <= '0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_comp_q     <= i_comp;
         r_comp_armed <= 1'b1;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_comp_rise) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            S_LOAD: begin
               r_ord   <= i_ord[ORD_W-1:0];
               r_n     <= w_n;
               r_board <= i_start_state[17:0];
               r_blank <= w_blank_pos;
               r_step  <= '0;
               if (w_blank_found) begin
                  r_state <= S_EMIT;
                  r_valid <= 1'b1;
                  r_last  <= (w_n == 5'd0);
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_EMIT: begin
               if (w_accept) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (!r_last) begin
                     r_state <= S_APPLY;
                  end else if (w_goal_ok) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_APPLY: begin
               if (w_legal) begin
                  r_board <= w_next_board;
                  r_blank <= w_target;
                  r_step  <= r_step + 5'd1;
                  r_valid <= 1'b1;
                  r_last  <= ((r_step + 5'd1) == r_n);
                  r_state <= S_EMIT;
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            S_ERR: begin
               if (w_comp_rise) begin
                  r_state <= S_LOAD;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out_if.out_state = r_board;
   assign out_if.step_idx  = r_step;
   assign out_if.out_valid = r_valid;
   assign out_if.out_last  = r_last;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_err            = r_err;
endmodule

// File: tb/tb_move_replayer.sv
// -----------------------------------------------------------------------------
// tb_move_replayer
//  Drives directed and random replays into move_replayer and compares every
//  emitted board, step index, last flag and the done/err/busy status against a
//  cell-array model of the 2x3 puzzle.
// -----------------------------------------------------------------------------
module tb_move_replayer;
   localparam logic [17:0] GOAL_BOARD = 18'o543210;
`ifdef MOVE_REPLAY_GOAL_CHECK_EN
   localparam bit GOAL_ON = 1'b1;
`else
   localparam bit GOAL_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [25:0] start_state = '0;
   logic        comp = 1'b0;
   logic [25:0] cnt = '0;
   logic [43:0] ord = '0;
   logic        busy;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   string       cur_name = "reset";
   logic [17:0] exp_boards[$];
   bit          exp_bad;

   move_replayer_if bus();

   move_replayer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start_state(start_state),
      .i_comp       (comp),
      .i_cnt        (cnt),
      .i_ord        (ord),
      .out_if       (bus),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s/%s observed=%0h expected=%0h", cur_name, tag, obs, exp);
      end
   endtask

   // Returns the cell the blank moves to, or -1 if the move leaves the board.
   function automatic int move_target(input int blank, input int mv);
      int r;
      int c;
      r = blank / 3;
      c = blank % 3;
      case (mv)
         0:       r = r - 1;
         1:       c = c + 1;
         2:       r = r + 1;
         default: c = c - 1;
      endcase
      if (r < 0 || r > 1 || c < 0 || c > 2) return -1;
      return r * 3 + c;
   endfunction

   function automatic logic [17:0] pack(input int cells[6]);
      logic [17:0] b;
      b = '0;
      for (int i = 0; i < 6; i++) b[3*i +: 3] = 3'(cells[i]);
      return b;
   endfunction

   task automatic build_model(input logic [17:0] st, input int n, input logic [43:0] o);
      int cells[6];
      int blank;
      int t;
      exp_boards.delete();
      exp_bad = 1'b0;
      blank = -1;
      for (int i = 0; i < 6; i++) begin
         cells[i] = int'(st[3*i +: 3]);
         if (cells[i] == 0 && blank < 0) blank = i;
      end
      if (blank < 0) begin
         exp_bad = 1'b1;
         return;
      end
      exp_boards.push_back(pack(cells));
      for (int k = 0; k < n; k++) begin
         t = move_target(blank, int'(o[2*k +: 2]));
         if (t < 0) begin
            exp_bad = 1'b1;
            return;
         end
         cells[blank] = cells[t];
         cells[t]     = 0;
         blank        = t;
         exp_boards.push_back(pack(cells));
      end
   endtask

   function automatic logic [17:0] rand_board();
      int cells[6];
      int j;
      int tmp;
      for (int i = 0; i < 6; i++) cells[i] = i;
      for (int i = 5; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         tmp = cells[i]; cells[i] = cells[j]; cells[j] = tmp;
      end
      return pack(cells);
   endfunction

   // Twenty legal moves from st, packed; the spare top ord bits stay random.
   function automatic logic [43:0] legal_walk(input logic [17:0] st);
      logic [43:0] o;
      int blank;
      int mv;
      int t;
      o = 44'({$urandom(), $urandom()});
      blank = 0;
      for (int i = 5; i >= 0; i--) if (st[3*i +: 3] == 3'd0) blank = i;
      for (int k = 0; k < 20; k++) begin
         t = -1;
         mv = 0;
         for (int tries = 0; tries < 64 && t < 0; tries++) begin
            mv = int'($urandom_range(0, 3));
            t = move_target(blank, mv);
         end
         o[2*k +: 2] = 2'(mv);
         if (t >= 0) blank = t;
      end
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stall_b1 >= 0 holds out_ready low that many cycles on beat 1; otherwise
   // every beat gets a random 0..3 cycle stall.
   task automatic run_replay(input string name, input logic [25:0] st, input logic [25:0] c,
                             input logic [43:0] o, input int stall_b1);
      int n;
      int nb;
      int stall;
      cur_name = name;
      n = (c[4:0] > 5'd20) ? 20 : int'(c[4:0]);
      build_model(st[17:0], n, o);
      nb = exp_boards.size();
      $display("replay %s n=%0d beats=%0d bad=%0b", name, n, nb, exp_bad);
      start_state = st;
      cnt         = c;
      ord         = o;
      comp        = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      comp = 1'b1;
      tick();
      check_eq("load_valid", 32'(bus.out_valid), 0);
      check_eq("load_err", 32'(err), 0);
      check_eq("load_busy", 32'(busy), 1);
      tick();
      if (nb == 0) begin
         check_eq("noblank_err", 32'(err), 1);
         check_eq("noblank_valid", 32'(bus.out_valid), 0);
         check_eq("noblank_busy", 32'(busy), 0);
      end
      for (int k = 0; k < nb; k++) begin
         check_eq("beat_valid", 32'(bus.out_valid), 1);
         check_eq("beat_state", 32'(bus.out_state), 32'(exp_boards[k]));
         check_eq("beat_step", 32'(bus.step_idx), k);
         check_eq("beat_last", 32'(bus.out_last), 32'(k == n));
         stall = (stall_b1 >= 0) ? ((k == 1) ? stall_b1 : 0) : int'($urandom_range(0, 3));
         for (int s = 0; s < stall; s++) begin
            tick();
            check_eq("hold_valid", 32'(bus.out_valid), 1);
            check_eq("hold_state", 32'(bus.out_state), 32'(exp_boards[k]));
            check_eq("hold_step", 32'(bus.step_idx), k);
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         if (k == n) begin
            if (GOAL_ON && exp_boards[k] != GOAL_BOARD) begin
               check_eq("goal_err", 32'(err), 1);
               check_eq("goal_nodone", 32'(done), 0);
               check_eq("goal_busy", 32'(busy), 0);
            end else begin
               check_eq("done_pulse", 32'(done), 1);
               check_eq("done_valid", 32'(bus.out_valid), 0);
               tick();
               check_eq("done_clear", 32'(done), 0);
               check_eq("idle_busy", 32'(busy), 0);
            end
         end else begin
            check_eq("apply_valid", 32'(bus.out_valid), 0);
            tick();
            if (k == nb - 1) begin
               check_eq("illegal_err", 32'(err), 1);
               check_eq("illegal_busy", 32'(busy), 0);
               check_eq("illegal_valid", 32'(bus.out_valid), 0);
            end
         end
      end
      // comp is still high here: it must not start another replay.
      tick();
      check_eq("no_retrigger", 32'(busy), 0);
      check_eq("no_retrigger_valid", 32'(bus.out_valid), 0);
   endtask

   task automatic reset_mid_replay();
      logic [17:0] st;
      bit hit;
      cur_name = "reset_mid";
      st = rand_board();
      start_state = 26'(st);
      cnt = 26'd3;
      ord = legal_walk(st);
      comp = 1'b0;
      tick();
      comp = 1'b1;
      bus.out_ready = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick();
         if (bus.out_valid && bus.step_idx == 5'd2) hit = 1'b1;
      end
      check_eq("reach_step2", 32'(hit), 1);
      $display("replay reset_mid at step 2");
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      check_eq("rst_state", 32'(bus.out_state), 0);
      check_eq("rst_step", 32'(bus.step_idx), 0);
      check_eq("rst_valid", 32'(bus.out_valid), 0);
      check_eq("rst_last", 32'(bus.out_last), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("rst_no_restart", 32'(busy), 0);
      end
   endtask

   initial begin
      logic [17:0] st;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("init_valid", 32'(bus.out_valid), 0);
      check_eq("init_busy", 32'(busy), 0);
      check_eq("init_err", 32'(err), 0);
      check_eq("init_done", 32'(done), 0);
      rst_n = 1'b1;
      repeat (2) tick();

      run_replay("t1_right", 26'(18'b101_011_100_010_000_001), 26'd1, 44'b01, -1);
      run_replay("t2_up_illegal", 26'(18'b101_011_100_010_000_001), 26'd1, 44'b00, -1);
      run_replay("t2_recover", 26'(18'b101_011_100_010_000_001), 26'd1, 44'b01, -1);
      run_replay("t3_zero", 26'(18'o123405), 26'd0, 44'hF_FFFF_FFFF, -1);
      st = rand_board();
      run_replay("t4_stall", 26'(st), 26'd3, legal_walk(st), 5);
      run_replay("goal_hit", 26'(18'o543201), 26'd1, 44'b11, -1);
      run_replay("goal_miss", 26'(18'o543210), 26'd1, 44'b01, -1);
      run_replay("no_blank", 26'(18'o123451), 26'd2, 44'd0, -1);
      run_replay("clamp", {8'hA5, 18'o543210}, 26'h3FFFFFF, legal_walk(18'o543210), -1);
      reset_mid_replay();

      for (int it = 0; it < 24; it++) begin
         if (it % 8 == 7) begin
            st = '0;
            for (int i = 0; i < 6; i++) st[3*i +: 3] = 3'($urandom_range(1, 7));
            run_replay("rand_noblank", {8'($urandom()), st}, 26'($urandom()), 44'({$urandom(), $urandom()}), -1);
         end else if (it % 2 == 0) begin
            st = rand_board();
            run_replay("rand_walk", {8'($urandom()), st}, 26'($urandom()), legal_walk(st), -1);
         end else begin
            st = rand_board();
            run_replay("rand_ord", {8'($urandom()), st}, 26'($urandom()), 44'({$urandom(), $urandom()}), -1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end
endmodule
